// File: rtl/pad_mux_ctrl_pkg.sv
// Shared types and helpers for the multi-design pad multiplexer.
//   state_e    : select FSM states (SAMPLE -> RUN | BAD)
//   sel_width  : select bus width for a given design count (min 1)
//   slice_base : base bit of a design's slice in a packed per-design bus
package pad_mux_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SAMPLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_BAD    = 2'd2
  } state_e;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int slice_base(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/pad_oe_turnaround.sv
// Per-pad output-enable register with turnaround insertion.
// A 0->1 request is delayed by TURNAROUND idle cycles (total 1+TURNAROUND);
// 1->0 is never delayed, so the pad always releases before a new drive.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_run          : datapath enabled (select FSM in RUN)
//   i_req          : requested enable from the selected design
//   o_oe           : registered pad output enable
module pad_oe_turnaround #(
  parameter int TURNAROUND = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_req,
  output logic o_oe
);

  logic       r_oe;
  logic [1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_oe  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (!i_run || !i_req) begin
      // drop immediately; also aborts a turnaround in progress
      r_oe  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (r_oe) begin
      r_oe  <= 1'b1;
    end else if (r_cnt != 2'd0) begin
      // enable rises on the edge that empties the counter
      r_cnt <= r_cnt - 2'd1;
      r_oe  <= (r_cnt == 2'd1);
    end else if (TURNAROUND == 0) begin
      r_oe  <= 1'b1;
    end else begin
      r_cnt <= TURNAROUND[1:0];
    end
  end

  assign o_oe = r_oe;

endmodule

// File: rtl/pad_mux_ctrl.sv
// Multi-design pad multiplexer. Samples the design-select straps after
// reset (synchroniser + stability filter), releases reset to the chosen
// design only, and registers its pad outputs/enables with turnaround.
//   clk, RESETn            : clock, async active-low reset
//   design_sel             : raw async strap pins
//   des_out / des_oe       : per-design pad out/oe, design d at [d*NUM_PADS +: NUM_PADS]
//   des_in                 : pad_in broadcast to all designs (combinational)
//   des_rst_n              : per-design active-low reset
//   pad_in/pad_out/pad_oe  : chip pad side
//   sel_latched, sel_valid : captured select, high while running
module pad_mux_ctrl
  import pad_mux_ctrl_pkg::*;
#(
  parameter int NUM_DESIGNS   = 32,
  parameter int NUM_PADS      = 42,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int TURNAROUND    = 1,
  localparam int SEL_W        = sel_width(NUM_DESIGNS)
) (
  input  logic                            clk,
  input  logic                            RESETn,
  input  logic [SEL_W-1:0]                design_sel,
  input  logic [NUM_DESIGNS*NUM_PADS-1:0] des_out,
  input  logic [NUM_DESIGNS*NUM_PADS-1:0] des_oe,
  output logic [NUM_PADS-1:0]             des_in,
  output logic [NUM_DESIGNS-1:0]          des_rst_n,
  input  logic [NUM_PADS-1:0]             pad_in,
  output logic [NUM_PADS-1:0]             pad_out,
  output logic [NUM_PADS-1:0]             pad_oe,
  output logic [SEL_W-1:0]                sel_latched,
  output logic                            sel_valid
);

  logic [SYNC_STAGES-1:0][SEL_W-1:0] r_sync;
  logic [SYNC_STAGES-1:0]            r_fill;
  logic [SEL_W-1:0]                  w_sync, r_prev, r_sel;
  logic [3:0]                        r_cnt, w_cnt_nxt;
  state_e                            r_state, w_state_nxt;
  logic                              w_latch, w_run;
  logic [NUM_PADS-1:0]               w_sel_out, w_sel_oe, r_pad_out;
  logic [NUM_DESIGNS-1:0]            r_des_rst_n;

  // Strap synchroniser; r_fill marks when the chain holds post-reset samples
  // so reset zeros are never counted as stable straps.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_sync <= '0;
      r_fill <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], design_sel};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev <= w_sync;
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= ST_SAMPLE;
      r_cnt   <= 4'd0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) r_sel <= w_sync;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      ST_SAMPLE: begin
        if (r_fill[SYNC_STAGES-1]) begin
          // cnt==0 means no previous valid sample yet: start a fresh run
          w_cnt_nxt = (r_cnt == 4'd0 || w_sync != r_prev) ? 4'd1 : r_cnt + 4'd1;
          if (w_cnt_nxt == 4'(STABLE_CYCLES)) begin
            w_latch     = 1'b1;
            w_state_nxt = (int'(w_sync) < NUM_DESIGNS) ? ST_RUN : ST_BAD;
          end
        end
      end
      default: ;  // RUN and BAD hold until reset
    endcase
  end

  assign w_run = (r_state == ST_RUN);

  // Selected design's slice; straps outside the design range pick nothing.
  always_comb begin
    w_sel_out = '0;
    w_sel_oe  = '0;
    for (int d = 0; d < NUM_DESIGNS; d++) begin
      if (r_sel == SEL_W'(d)) begin
        w_sel_out = des_out[slice_base(d, NUM_PADS) +: NUM_PADS];
        w_sel_oe  = des_oe[slice_base(d, NUM_PADS) +: NUM_PADS];
      end
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_pad_out   <= '0;
      r_des_rst_n <= '0;
    end else begin
      r_pad_out   <= w_run ? w_sel_out : '0;
      r_des_rst_n <= w_run ? (NUM_DESIGNS'(1) << r_sel) : '0;
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    pad_oe_turnaround #(.TURNAROUND(TURNAROUND)) u_ta (
      .i_clk   (clk),
      .i_rst_n (RESETn),
      .i_run   (w_run),
      .i_req   (w_sel_oe[p]),
      .o_oe    (pad_oe[p])
    );
  end

  assign des_in      = pad_in;
  assign pad_out     = r_pad_out;
  assign des_rst_n   = r_des_rst_n;
  assign sel_latched = r_sel;
  assign sel_valid   = w_run;

endmodule

// File: tb/tb_pad_mux_ctrl.sv
module tb_pad_mux_ctrl;
  localparam int ND   = 32;
  localparam int ND2  = 24;
  localparam int NP   = 42;
  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int TA   = 1;

  logic clk = 1'b0;
  logic RESETn;
  logic [4:0] sel, sel2;
  logic [ND*NP-1:0]  des_out, des_oe;
  logic [ND2*NP-1:0] des_out2, des_oe2;
  logic [NP-1:0] pad_in;
  logic [NP-1:0] des_in, pad_out, pad_oe, des_in2, pad_out2, pad_oe2;
  logic [ND-1:0]  des_rst_n;
  logic [ND2-1:0] des_rst_n2;
  logic [4:0] sel_latched, sel_latched2;
  logic sel_valid, sel_valid2;

  always #5 clk = ~clk;

  pad_mux_ctrl dut (
    .clk(clk), .RESETn(RESETn), .design_sel(sel), .des_out(des_out), .des_oe(des_oe),
    .des_in(des_in), .des_rst_n(des_rst_n), .pad_in(pad_in), .pad_out(pad_out),
    .pad_oe(pad_oe), .sel_latched(sel_latched), .sel_valid(sel_valid));

  pad_mux_ctrl #(.NUM_DESIGNS(ND2)) dut24 (
    .clk(clk), .RESETn(RESETn), .design_sel(sel2), .des_out(des_out2), .des_oe(des_oe2),
    .des_in(des_in2), .des_rst_n(des_rst_n2), .pad_in(pad_in), .pad_out(pad_out2),
    .pad_oe(pad_oe2), .sel_latched(sel_latched2), .sel_valid(sel_valid2));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode 0=sampling, 1=running, 2=bad strap
  int          m_mode;
  int          m_edges;
  logic [4:0]  m_sel;
  logic [4:0]  q[$];
  int          runlen[NP];
  logic [NP-1:0] m_out, m_oe;
  logic [31:0] m_rst;
  int          force_oe = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_edges = 0; m_sel = '0; q.delete();
    m_out = '0; m_oe = '0; m_rst = '0;
    for (int p = 0; p < NP; p++) runlen[p] = 0;
  endtask

  // One clock edge of the behaviour: an enable is on once the request has
  // been seen high for TA+1 consecutive sampled edges; selection latches
  // once the last STAB synchronised samples (SYNC edges old) all agree.
  task automatic model_edge();
    int k;
    bit same;
    if (m_mode == 1) begin
      for (int p = 0; p < NP; p++) begin
        runlen[p] = des_oe[m_sel*NP + p] ? runlen[p] + 1 : 0;
        m_oe[p]   = (runlen[p] >= TA + 1);
      end
      m_out = des_out[m_sel*NP +: NP];
      m_rst = 32'd1 << m_sel;
    end else begin
      for (int p = 0; p < NP; p++) runlen[p] = 0;
      m_out = '0; m_oe = '0; m_rst = '0;
    end
    q.push_back(sel);
    m_edges++;
    k = m_edges;
    if (m_mode == 0 && k - SYNC - STAB >= 0) begin
      same = 1'b1;
      for (int i = k - SYNC - STAB; i < k - SYNC; i++)
        if (q[i] != q[k-SYNC-1]) same = 1'b0;
      if (same) begin
        m_sel  = q[k-SYNC-1];
        m_mode = (m_sel < ND) ? 1 : 2;
      end
    end
  endtask

  task automatic check_all();
    chk("pad_out", 64'(pad_out), 64'(m_out));
    chk("pad_oe", 64'(pad_oe), 64'(m_oe));
    chk("des_rst_n", 64'(des_rst_n), 64'(m_rst));
    chk("sel_latched", 64'(sel_latched), 64'(m_sel));
    chk("sel_valid", 64'(sel_valid), 64'(m_mode == 1));
    chk("des_in", 64'(des_in), 64'(pad_in));
    // 24-design instance, strap 30: bad from the 6th edge after release
    chk("bad_sel", 64'(sel_latched2), (m_edges >= SYNC + STAB) ? 64'd30 : 64'd0);
    chk("bad_valid", 64'(sel_valid2), 64'd0);
    chk("bad_oe", 64'(pad_oe2), 64'd0);
    chk("bad_out", 64'(pad_out2), 64'd0);
    chk("bad_rst", 64'(des_rst_n2), 64'd0);
    chk("bad_des_in", 64'(des_in2), 64'(pad_in));
  endtask

  task automatic drive_random();
    for (int i = 0; i < ND*NP; i++) begin
      des_out[i] = 1'($urandom_range(0, 1));
      des_oe[i]  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < ND2*NP; i++) begin
      des_out2[i] = 1'($urandom_range(0, 1));
      des_oe2[i]  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < NP; i++) pad_in[i] = 1'($urandom_range(0, 1));
    if (force_oe >= 0) des_oe[28*NP] = force_oe[0];
  endtask

  task automatic step();
    @(posedge clk);
    if (RESETn) model_edge();
    @(negedge clk);
    check_all();
    drive_random();
  endtask

  initial begin
    int first;
    bit pat [10];
    pat = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 0};
    RESETn = 1'b0; sel = 5'd28; sel2 = 5'd30;
    model_reset();
    drive_random();
    #1;
    // reset state
    for (int i = 0; i < 3; i++) step();

    // static strap 28: sel_valid rises on the 6th edge after release
    RESETn = 1'b1;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (sel_valid && first == 0) first = k;
    end
    chk("valid_rise_edge", 64'(first), 64'(SYNC + STAB));
    chk("rst_onehot", 64'(des_rst_n), 64'(32'd1 << 28));

    for (int i = 0; i < 60; i++) step();

    // directed turnaround on pad 0: one-cycle pulse must never drive
    for (int i = 0; i < 10; i++) begin
      force_oe = int'(pat[i]);
      step();
      if (i >= 2) chk("ta_oe0", 64'(pad_oe[0]), 64'(pat[i-1] & pat[i-2]));
    end
    force_oe = -1;

    // strap changes mid-run are ignored
    sel = 5'd5;
    for (int i = 0; i < 10; i++) step();
    chk("midrun_sel", 64'(sel_latched), 64'd28);

    // make every pad drive, then assert reset between edges
    force_oe = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) des_oe[28*NP + p] = 1'b1;
      @(posedge clk);
      model_edge();
    end
    force_oe = -1;
    @(negedge clk);
    chk("pre_reset_oe", 64'(pad_oe), 64'(m_oe));
    #2 RESETn = 1'b0;
    #1;
    chk("async_oe", 64'(pad_oe), 64'd0);
    chk("async_rst", 64'(des_rst_n), 64'd0);
    chk("async_valid", 64'(sel_valid), 64'd0);
    model_reset();
    for (int i = 0; i < 2; i++) step();

    // toggle 28/29 every 2 cycles: no lock until it holds 29
    RESETn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sel = ((i / 2) % 2 == 1) ? 5'd29 : 5'd28;
      step();
      chk("toggle_no_run", 64'(sel_valid), 64'd0);
    end
    sel = 5'd29;
    for (int i = 0; i < 20; i++) step();
    chk("resample_sel", 64'(sel_latched), 64'd29);
    chk("resample_valid", 64'(sel_valid), 64'd1);
    for (int i = 0; i < 20; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
